// File: rtl/mem_access_unit.sv
// Word-addressed data memory behind the MDR with a programmable wait-state sequencer.
// Each request is accepted in IDLE, waits WAIT_CYCLES edges, then completes with a one-cycle ack.
module mem_access_unit #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 8,
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wrData,
    output logic [DATA_W-1:0] rdData,
    output logic              ack,
    output logic              err,
    output logic              busy
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DONE
    } state_t;

    localparam logic [3:0]      WAIT_INIT = 4'(WAIT_CYCLES);
    localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                we_q, we_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rd_data_q, rd_data_d;
    logic                ack_q, ack_d;
    logic                err_q, err_d;
    logic                busy_q, busy_d;

    logic                do_access;
    logic                in_range;
    logic                mem_we;
    logic [ADDR_W-1:0]   acc_addr;
    logic                acc_we;
    logic [DATA_W-1:0]   acc_wdata;

    logic [DATA_W-1:0]   mem [DEPTH];

    // NOTE: every signal gets a default before the case so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        we_d      = we_q;
        wdata_d   = wdata_q;
        rd_data_d = rd_data_q;
        ack_d     = 1'b0;
        err_d     = 1'b0;
        do_access = 1'b0;
        mem_we    = 1'b0;
        acc_addr  = addr_q;
        acc_we    = we_q;
        acc_wdata = wdata_q;

        unique case (state_q)
            ST_IDLE: begin
                if (req) begin
                    if (WAIT_CYCLES == 0) begin
                        // Zero wait states: the access uses the live inputs on the accept edge.
                        do_access = 1'b1;
                        acc_addr  = addr;
                        acc_we    = we;
                        acc_wdata = wrData;
                        state_d   = ST_DONE;
                    end else begin
                        addr_d  = addr;
                        we_d    = we;
                        wdata_d = wrData;
                        cnt_d   = WAIT_INIT;
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    do_access = 1'b1;
                    state_d   = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        in_range = ({1'b0, acc_addr} < DEPTH_LIM);
        if (do_access) begin
            ack_d = 1'b1;
            if (!in_range) begin
                rd_data_d = '0;
                err_d     = 1'b1;
            end else if (acc_we) begin
                mem_we = 1'b1;
            end else begin
                rd_data_d = mem[acc_addr];
            end
        end

        busy_d = (state_d != ST_IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            we_q      <= 1'b0;
            wdata_q   <= '0;
            rd_data_q <= '0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            we_q      <= we_d;
            wdata_q   <= wdata_d;
            rd_data_q <= rd_data_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
        end
    end

    // NOTE: the memory array has no reset; its contents survive reset by design.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[acc_addr] <= acc_wdata;
        end
    end

    assign rdData = rd_data_q;
    assign ack    = ack_q;
    assign err    = err_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: four instances cover the wait-state and depth variants.
// Instance 0: W=2 DEPTH=200, 1: W=0, 2: W=3, 3: W=4 (DEPTH=256 for 1..3).
module tb_mem_access_unit;

    localparam int N_INST = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        req [N_INST];
    logic        we;
    logic [7:0]  addr;
    logic [15:0] wr_data;
    logic [15:0] rd_data [N_INST];
    logic        ack [N_INST];
    logic        err [N_INST];
    logic        busy [N_INST];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.DATA_W(16), .ADDR_W(8), .DEPTH(200), .WAIT_CYCLES(2)) u_w2 (
        .clk(clk), .reset(reset), .req(req[0]), .we(we), .addr(addr), .wrData(wr_data),
        .rdData(rd_data[0]), .ack(ack[0]), .err(err[0]), .busy(busy[0]));
    mem_access_unit #(.DATA_W(16), .ADDR_W(8), .DEPTH(256), .WAIT_CYCLES(0)) u_w0 (
        .clk(clk), .reset(reset), .req(req[1]), .we(we), .addr(addr), .wrData(wr_data),
        .rdData(rd_data[1]), .ack(ack[1]), .err(err[1]), .busy(busy[1]));
    mem_access_unit #(.DATA_W(16), .ADDR_W(8), .DEPTH(256), .WAIT_CYCLES(3)) u_w3 (
        .clk(clk), .reset(reset), .req(req[2]), .we(we), .addr(addr), .wrData(wr_data),
        .rdData(rd_data[2]), .ack(ack[2]), .err(err[2]), .busy(busy[2]));
    mem_access_unit #(.DATA_W(16), .ADDR_W(8), .DEPTH(256), .WAIT_CYCLES(4)) u_w4 (
        .clk(clk), .reset(reset), .req(req[3]), .we(we), .addr(addr), .wrData(wr_data),
        .rdData(rd_data[3]), .ack(ack[3]), .err(err[3]), .busy(busy[3]));

    typedef struct {
        logic        req;
        logic        we;
        logic [7:0]  addr;
        logic [15:0] wdata;
        logic        exp_ack;
        logic        exp_err;
        logic        exp_busy;
        logic [15:0] exp_rd;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Four cycle rows of one W=2 transaction: accept, wait, ack, back to idle.
    task automatic add_txn(input logic w, input logic [7:0] a, input logic [15:0] d,
                           input logic [15:0] rd_before, input logic [15:0] rd_after,
                           input logic e);
        vecs.push_back('{1'b1, w, a, d, 1'b0, 1'b0, 1'b1, rd_before});
        vecs.push_back('{1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 1'b1, rd_before});
        vecs.push_back('{1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, e, 1'b1, rd_after});
        vecs.push_back('{1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 1'b0, rd_after});
    endtask

    // One transaction on instance idx; lat counts ticks from the accept edge to ack.
    task automatic txn(input int idx, input logic w, input logic [7:0] a, input logic [15:0] d,
                       output int lat, output logic [15:0] rd, output logic e);
        req[idx] = 1'b1;
        we       = w;
        addr     = a;
        wr_data  = d;
        tick();
        req[idx] = 1'b0;
        lat      = 1;
        while (ack[idx] !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
        rd = rd_data[idx];
        e  = err[idx];
        tick();
    endtask

    initial begin
        int          lat;
        logic [15:0] rd;
        logic        e;

        reset   = 1'b1;
        we      = 1'b0;
        addr    = '0;
        wr_data = '0;
        for (int i = 0; i < N_INST; i++) req[i] = 1'b0;
        #2 reset = 1'b0;
        #20 reset = 1'b1;

        // Idle after reset.
        for (int c = 0; c < 10; c++) begin
            tick();
            for (int i = 0; i < N_INST; i++) begin
                check($sformatf("idle%0d_i%0d_rd", c, i), rd_data[i], 16'h0000);
                check($sformatf("idle%0d_i%0d_ack", c, i), 16'(ack[i]), 16'h0);
                check($sformatf("idle%0d_i%0d_err", c, i), 16'(err[i]), 16'h0);
                check($sformatf("idle%0d_i%0d_busy", c, i), 16'(busy[i]), 16'h0);
            end
        end

        // W=2, DEPTH=200 cycle-accurate vectors.
        add_txn(1'b1, 8'h05, 16'hBEEF, 16'h0000, 16'h0000, 1'b0);
        add_txn(1'b0, 8'h05, 16'h0000, 16'h0000, 16'hBEEF, 1'b0);
        add_txn(1'b1, 8'hC8, 16'hFFFF, 16'hBEEF, 16'h0000, 1'b1);
        add_txn(1'b1, 8'hC7, 16'h1357, 16'h0000, 16'h0000, 1'b0);
        add_txn(1'b0, 8'hC8, 16'h0000, 16'h0000, 16'h0000, 1'b1);
        add_txn(1'b0, 8'hC7, 16'h0000, 16'h0000, 16'h1357, 1'b0);
        add_txn(1'b0, 8'h05, 16'h0000, 16'h1357, 16'hBEEF, 1'b0);
        add_txn(1'b0, 8'hFF, 16'h0000, 16'hBEEF, 16'h0000, 1'b1);
        foreach (vecs[i]) begin
            req[0]  = vecs[i].req;
            we      = vecs[i].we;
            addr    = vecs[i].addr;
            wr_data = vecs[i].wdata;
            tick();
            check($sformatf("vec%0d_ack", i), 16'(ack[0]), 16'(vecs[i].exp_ack));
            check($sformatf("vec%0d_err", i), 16'(err[0]), 16'(vecs[i].exp_err));
            check($sformatf("vec%0d_busy", i), 16'(busy[0]), 16'(vecs[i].exp_busy));
            check($sformatf("vec%0d_rd", i), rd_data[0], vecs[i].exp_rd);
        end

        // W=0: ack in the cycle right after each accept.
        txn(1, 1'b1, 8'h10, 16'h1234, lat, rd, e);
        check("w0_wr_lat", 16'(lat), 16'd1);
        check("w0_wr_err", 16'(e), 16'h0);
        txn(1, 1'b0, 8'h10, 16'h0000, lat, rd, e);
        check("w0_rd_lat", 16'(lat), 16'd1);
        check("w0_rd_data", rd, 16'h1234);
        req[1] = 1'b1;
        we     = 1'b0;
        addr   = 8'h10;
        for (int c = 0; c < 6; c++) begin
            tick();
            check($sformatf("w0_held%0d_ack", c), 16'(ack[1]), (c % 2 == 0) ? 16'h1 : 16'h0);
            check($sformatf("w0_held%0d_busy", c), 16'(busy[1]), (c % 2 == 0) ? 16'h1 : 16'h0);
        end
        req[1] = 1'b0;
        tick();
        check("w0_held_rd", rd_data[1], 16'h1234);

        // W=3: inputs changed during WAIT and a req during DONE have no effect.
        req[2]  = 1'b1;
        we      = 1'b1;
        addr    = 8'h07;
        wr_data = 16'hCAFE;
        tick();
        check("w3_busy_accept", 16'(busy[2]), 16'h1);
        req[2]  = 1'b0;
        we      = 1'b0;
        addr    = 8'h08;
        wr_data = 16'hDEAD;
        tick();
        tick();
        check("w3_no_early_ack", 16'(ack[2]), 16'h0);
        tick();
        check("w3_ack", 16'(ack[2]), 16'h1);
        req[2]  = 1'b1;
        we      = 1'b1;
        addr    = 8'h07;
        wr_data = 16'h5555;
        tick();
        check("w3_done_ack", 16'(ack[2]), 16'h0);
        check("w3_done_ignored", 16'(busy[2]), 16'h0);
        req[2] = 1'b0;
        tick();
        check("w3_still_idle", 16'(busy[2]), 16'h0);
        txn(2, 1'b0, 8'h07, 16'h0000, lat, rd, e);
        check("w3_rd_lat", 16'(lat), 16'd4);
        check("w3_rd_data", rd, 16'hCAFE);

        // W=4: reset during WAIT aborts the write.
        txn(3, 1'b1, 8'h03, 16'h1111, lat, rd, e);
        check("w4_wr_lat", 16'(lat), 16'd5);
        txn(3, 1'b0, 8'h03, 16'h0000, lat, rd, e);
        check("w4_rd_pre", rd, 16'h1111);
        req[3]  = 1'b1;
        we      = 1'b1;
        addr    = 8'h03;
        wr_data = 16'hAAAA;
        tick();
        req[3] = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        #1;
        check("w4_rst_busy", 16'(busy[3]), 16'h0);
        check("w4_rst_ack", 16'(ack[3]), 16'h0);
        check("w4_rst_err", 16'(err[3]), 16'h0);
        check("w4_rst_rd", rd_data[3], 16'h0000);
        tick();
        reset = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            check($sformatf("w4_post%0d_ack", c), 16'(ack[3]), 16'h0);
            check($sformatf("w4_post%0d_busy", c), 16'(busy[3]), 16'h0);
        end
        txn(3, 1'b0, 8'h03, 16'h0000, lat, rd, e);
        check("w4_rd_lat", 16'(lat), 16'd5);
        check("w4_rd_kept", rd, 16'h1111);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
